xcvr_pll_lock_seq: RTL and testbench

//  Sequences bring-up of the transceiver TX PLL and its lanes. Synchronises the PLL

---
 rtl/xcvr_pll_lock_seq.sv | 171 +++++++++++++++++
 tb/tb_xcvr_pll_lock_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/xcvr_pll_lock_seq.sv
// TX PLL lock sequencer: synchronises and debounces PLL lock, then releases lane resets.
// Define XCVR_PLL_SEQ_RELOCK_CNT_EN to build the saturating relock counter.
module xcvr_pll_lock_seq #(
  parameter int unsigned DEBOUNCE_CYC = 1024,
  parameter int unsigned RELEASE_DLY  = 64,
  parameter int unsigned LOCK_TIMEOUT = 1000000,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_restart,
  input  logic             i_pll_lock,
  output logic             o_lane_rst_n,
  output logic             o_ready,
  output logic             o_lock_lost,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_relock_cnt,
  output logic [2:0]       o_state
);

  localparam int unsigned DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned REL_W = (RELEASE_DLY  > 1) ? $clog2(RELEASE_DLY)  : 1;
  localparam int unsigned TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_DLY - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_DEBOUNCE  = 3'd2,
    S_RELEASE   = 3'd3,
    S_READY     = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  logic [1:0]       r_sync;
  logic             w_lock_s;
  state_t           r_state, w_state_nxt;
  logic [DEB_W-1:0] r_deb_cnt, w_deb_nxt;
  logic [REL_W-1:0] r_rel_cnt, w_rel_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
  logic             r_lock_lost, w_lock_lost_nxt;
  logic             r_fault, w_fault_nxt;
  logic             r_lane_rst_n, r_ready;

  assign w_lock_s = r_sync[1];

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_nxt     = r_state;
    w_deb_nxt       = r_deb_cnt;
    w_rel_nxt       = r_rel_cnt;
    w_tmo_nxt       = r_tmo_cnt;
    w_lock_lost_nxt = r_lock_lost;
    w_fault_nxt     = r_fault;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_deb_nxt   = '0;
      w_rel_nxt   = '0;
      w_tmo_nxt   = '0;
    end else if (i_restart && (r_state != S_IDLE)) begin
      w_state_nxt     = S_WAIT_LOCK;
      w_deb_nxt       = '0;
      w_rel_nxt       = '0;
      w_tmo_nxt       = '0;
      w_lock_lost_nxt = 1'b0;
      w_fault_nxt     = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT_LOCK;
          w_tmo_nxt   = '0;
        end
        S_WAIT_LOCK, S_DEBOUNCE: begin
          // Timeout is checked first so it beats a same-cycle lane release.
          if (r_tmo_cnt == TMO_LAST) begin
            w_state_nxt = S_FAULT;
            w_fault_nxt = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
            if (r_state == S_WAIT_LOCK) begin
              if (w_lock_s) begin
                w_state_nxt = S_DEBOUNCE;
                w_deb_nxt   = '0;
              end
            end else if (!w_lock_s) begin
              w_state_nxt = S_WAIT_LOCK;
            end else if (r_deb_cnt == DEB_LAST) begin
              w_state_nxt = S_RELEASE;
              w_rel_nxt   = '0;
            end else begin
              w_deb_nxt = r_deb_cnt + DEB_W'(1);
            end
          end
        end
        S_RELEASE: begin
          if (!w_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_tmo_nxt   = '0;
          end else if (r_rel_cnt == REL_LAST) begin
            w_state_nxt = S_READY;
          end else begin
            w_rel_nxt = r_rel_cnt + REL_W'(1);
          end
        end
        S_READY: begin
          if (!w_lock_s) begin
            w_state_nxt     = S_WAIT_LOCK;
            w_tmo_nxt       = '0;
            w_lock_lost_nxt = 1'b1;
          end
        end
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync       <= '0;
      r_state      <= S_IDLE;
      r_deb_cnt    <= '0;
      r_rel_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_lock_lost  <= 1'b0;
      r_fault      <= 1'b0;
      r_lane_rst_n <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_pll_lock};
      r_state      <= w_state_nxt;
      r_deb_cnt    <= w_deb_nxt;
      r_rel_cnt    <= w_rel_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_lock_lost  <= w_lock_lost_nxt;
      r_fault      <= w_fault_nxt;
      r_lane_rst_n <= (w_state_nxt == S_RELEASE) || (w_state_nxt == S_READY);
      r_ready      <= (w_state_nxt == S_READY);
    end
  end

`ifdef XCVR_PLL_SEQ_RELOCK_CNT_EN
  logic [CNT_W-1:0] r_relock_cnt;
  logic             w_relock_clr, w_relock_inc;

  assign w_relock_clr = i_enable && i_restart && (r_state != S_IDLE);
  assign w_relock_inc = i_enable && !w_relock_clr && (r_state == S_READY) && !w_lock_s;

  always_ff @(posedge i_clk) begin
    if (i_reset || w_relock_clr) begin
      r_relock_cnt <= '0;
    end else if (w_relock_inc && (r_relock_cnt != '1)) begin
      r_relock_cnt <= r_relock_cnt + CNT_W'(1);
    end
  end

  assign o_relock_cnt = r_relock_cnt;
`else
  assign o_relock_cnt = '0;
`endif

  assign o_lane_rst_n = r_lane_rst_n;
  assign o_ready      = r_ready;
  assign o_lock_lost  = r_lock_lost;
  assign o_fault      = r_fault;
  assign o_state      = r_state;

endmodule

// File: tb/tb_xcvr_pll_lock_seq.sv
// Self-checking bench for xcvr_pll_lock_seq: directed bring-up scenarios plus random
// lock/enable/restart traffic against a phase-level reference model.
module tb_xcvr_pll_lock_seq;

  localparam int DEB  = 16;
  localparam int RDLY = 4;
  localparam int TMO  = 100;
  localparam int CW   = 8;
  localparam int RELOCK_MAX = (1 << CW) - 1;
`ifdef XCVR_PLL_SEQ_RELOCK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_reset, i_enable, i_restart, i_pll_lock;
  logic          o_lane_rst_n, o_ready, o_lock_lost, o_fault;
  logic [CW-1:0] o_relock_cnt;
  logic [2:0]    o_state;

  always #5 clk = ~clk;

  xcvr_pll_lock_seq #(
    .DEBOUNCE_CYC(DEB), .RELEASE_DLY(RDLY), .LOCK_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_restart(i_restart),
    .i_pll_lock(i_pll_lock), .o_lane_rst_n(o_lane_rst_n), .o_ready(o_ready),
    .o_lock_lost(o_lock_lost), .o_fault(o_fault), .o_relock_cnt(o_relock_cnt),
    .o_state(o_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
  endtask

  // Reference model: lock search is one phase tracked by elapsed cycles and the
  // current run of consecutive lock samples, rather than separate sub-states.
  typedef enum int {M_IDLE, M_SEEK, M_REL, M_RDY, M_FLT} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_seek_n = 0, m_run = 0, m_rel_n = 0, m_relock = 0;
  bit      m_lost = 0, m_fault = 0;
  bit      m_pipe[$] = '{1'b0, 1'b0};

  task automatic model_step(input bit en, input bit rs, input bit rst, input bit pl);
    bit ls;
    if (rst) begin
      m_pipe  = '{1'b0, 1'b0};
      m_phase = M_IDLE;
      m_lost  = 0; m_fault = 0; m_relock = 0;
      return;
    end
    ls = m_pipe.pop_front();
    m_pipe.push_back(pl);
    if (!en) begin
      m_phase = M_IDLE;
    end else if (rs && m_phase != M_IDLE) begin
      m_phase = M_SEEK; m_seek_n = 0; m_run = 0;
      m_lost = 0; m_fault = 0; m_relock = 0;
    end else begin
      case (m_phase)
        M_IDLE: begin m_phase = M_SEEK; m_seek_n = 0; m_run = 0; end
        M_SEEK: begin
          m_seek_n++;
          m_run = ls ? m_run + 1 : 0;
          if (m_seek_n == TMO) begin
            m_phase = M_FLT; m_fault = 1;
          end else if (m_run == DEB + 1) begin
            m_phase = M_REL; m_rel_n = 0;
          end
        end
        M_REL: begin
          if (!ls) begin
            m_phase = M_SEEK; m_seek_n = 0; m_run = 0;
          end else begin
            m_rel_n++;
            if (m_rel_n == RDLY) m_phase = M_RDY;
          end
        end
        M_RDY: begin
          if (!ls) begin
            m_phase = M_SEEK; m_seek_n = 0; m_run = 0; m_lost = 1;
            if (CNT_EN && m_relock < RELOCK_MAX) m_relock++;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] exp_state();
    case (m_phase)
      M_IDLE:  return 32'd0;
      M_SEEK:  return (m_run == 0) ? 32'd1 : 32'd2;
      M_REL:   return 32'd3;
      M_RDY:   return 32'd4;
      default: return 32'd5;
    endcase
  endfunction

  task automatic compare_all();
    check("state",      32'(o_state),      exp_state());
    check("lane_rst_n", 32'(o_lane_rst_n), 32'(m_phase == M_REL || m_phase == M_RDY));
    check("ready",      32'(o_ready),      32'(m_phase == M_RDY));
    check("lock_lost",  32'(o_lock_lost),  32'(m_lost));
    check("fault",      32'(o_fault),      32'(m_fault));
    check("relock_cnt", 32'(o_relock_cnt), 32'(m_relock));
  endtask

  // Drive one cycle of inputs away from the edge, step the model on the edge,
  // sample DUT outputs on the following falling edge.
  task automatic cycle(input bit en, input bit rs, input bit rst, input bit pl);
    i_enable = en; i_restart = rs; i_reset = rst; i_pll_lock = pl;
    @(posedge clk);
    model_step(en, rs, rst, pl);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  initial begin
    int lane_at, ready_at, fault_at, rises;
    bit prev_ready;
    i_enable = 0; i_restart = 0; i_reset = 1; i_pll_lock = 0;

    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);

    // Clean bring-up: lock rises at cycle 10.
    cyc = 0; lane_at = -1; ready_at = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0, i >= 10);
      if (o_lane_rst_n && lane_at < 0) lane_at = cyc;
      if (o_ready && ready_at < 0) ready_at = cyc;
    end
    check("bringup_lane_cycle", 32'(lane_at), 32'd29);
    check("bringup_ready_cycle", 32'(ready_at), 32'd33);
    check("bringup_fault", 32'(o_fault), 32'd0);

    // One-cycle lock glitch at debounce count 10.
    cycle(0, 0, 1, 0);
    cyc = 0; lane_at = -1; ready_at = -1;
    for (int i = 0; i < 60; i++) begin
      cycle(1, 0, 0, i >= 10 && i != 21);
      if (o_lane_rst_n && lane_at < 0) lane_at = cyc;
      if (o_ready && ready_at < 0) ready_at = cyc;
    end
    check("glitch_lane_cycle", 32'(lane_at), 32'd41);
    check("glitch_ready_cycle", 32'(ready_at), 32'd45);

    // No lock: timeout, then restart.
    cycle(0, 0, 1, 0);
    cyc = 0; fault_at = -1;
    for (int i = 0; i < 110; i++) begin
      cycle(1, 0, 0, 0);
      if (o_fault && fault_at < 0) fault_at = cyc;
    end
    check("timeout_cycle", 32'(fault_at), 32'd101);
    check("timeout_lane", 32'(o_lane_rst_n), 32'd0);
    cycle(1, 1, 0, 0);
    check("restart_fault", 32'(o_fault), 32'd0);
    check("restart_state", 32'(o_state), 32'd1);

    // Three lock drops while READY.
    rises = 0; prev_ready = 0;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 30; i++) begin
        cycle(1, 0, 0, 1);
        if (o_ready && !prev_ready) rises++;
        prev_ready = o_ready;
      end
      if (d < 3) for (int i = 0; i < 3; i++) begin
        cycle(1, 0, 0, 0);
        prev_ready = o_ready;
      end
    end
    check("relock_ready_rises", 32'(rises), 32'd4);
    check("relock_lost", 32'(o_lock_lost), 32'd1);
    check("relock_count", 32'(o_relock_cnt), CNT_EN ? 32'd3 : 32'd0);

    // ENABLE=0 with RESTART while READY: IDLE, sticky flag kept.
    cycle(0, 1, 0, 1);
    check("en0_state", 32'(o_state), 32'd0);
    check("en0_lane", 32'(o_lane_rst_n), 32'd0);
    check("en0_lost", 32'(o_lock_lost), 32'd1);

    // Reset in the middle of DEBOUNCE.
    for (int k = 0; k < 40 && o_state != 3'd2; k++) cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("deb_reached", 32'(o_state), 32'd2);
    cycle(1, 0, 1, 1);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_lane", 32'(o_lane_rst_n), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_lost", 32'(o_lock_lost), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_relock", 32'(o_relock_cnt), 32'd0);

    // 257 lock drops: counter saturates.
    for (int d = 0; d < 257; d++) begin
      for (int i = 0; i < 30; i++) cycle(1, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    end
    check("sat_relock", 32'(o_relock_cnt), CNT_EN ? 32'd255 : 32'd0);

    // Random lock segments with occasional enable drops, restarts and resets.
    for (int s = 0; s < 120; s++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 45));
      for (int i = 0; i < len; i++) begin
        cycle($urandom_range(0, 99) != 0, $urandom_range(0, 149) == 0,
              $urandom_range(0, 999) == 0, lvl);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
